ret_addr_stack: RTL

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

---
 rtl/ret_addr_stack_pkg.sv | 49 ++++
 rtl/ret_addr_stack.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ret_addr_stack_pkg.sv
// ret_addr_stack_pkg
// Shared core parameters for the return-address stack, plus the command
// decode used by the stack. The branch predictor imports the same
// RAS_WIDTH/RAS_DEPTH constants so both agree on entry width and depth.
//
// Contents:
//   RAS_WIDTH   default entry width (bits)
//   RAS_DEPTH   default entry count (power of two, >= 2)
//   ras_cmd_e   resolved per-cycle command after priority
//   ras_decode  priority resolution: flush > restore > push/pop
package ret_addr_stack_pkg;

    localparam int RAS_WIDTH = 32;
    localparam int RAS_DEPTH = 8;

    typedef enum logic [2:0] {
        CMD_IDLE    = 3'd0,
        CMD_FLUSH   = 3'd1,
        CMD_RESTORE = 3'd2,
        CMD_PUSH    = 3'd3,
        CMD_POP     = 3'd4,
        CMD_REPLACE = 3'd5
    } ras_cmd_e;

    // Reset is handled separately in the register process and wins over
    // everything decoded here. Push+pop on an empty stack is a plain push.
    function automatic ras_cmd_e ras_decode(
        input logic flush,
        input logic restore,
        input logic push,
        input logic pop,
        input logic nonempty
    );
        ras_cmd_e cmd;
        cmd = CMD_IDLE;
        if (flush)
            cmd = CMD_FLUSH;
        else if (restore)
            cmd = CMD_RESTORE;
        else if (push && pop && nonempty)
            cmd = CMD_REPLACE;
        else if (push)
            cmd = CMD_PUSH;
        else if (pop)
            cmd = CMD_POP;
        return cmd;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack
// Circular return-address stack with overwrite-oldest on overflow and
// checkpoint restore of pointer/occupancy (for branch mispredict recovery).
//
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        synchronous, active-high
//   push         push data_in
//   pop          remove top entry
//   data_in      value to push
//   flush        discard all entries
//   restore      load tos_ptr/count from restore_tos/restore_cnt
//   restore_tos  checkpointed top-of-stack pointer
//   restore_cnt  checkpointed occupancy (clamped to DEPTH)
//   data_out     top entry, 0 when empty
//   empty/full   decodes of count
//   count        valid entries, 0..DEPTH
//   tos_ptr      current top pointer
//   overflow     one-cycle pulse: a push dropped the oldest entry
//   underflow    one-cycle pulse: pop on an empty stack
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int WIDTH = RAS_WIDTH,
    parameter int DEPTH = RAS_DEPTH,
    // Derived; leave at default.
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flush,
    input  logic             restore,
    input  logic [PW-1:0]    restore_tos,
    input  logic [PW:0]      restore_cnt,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [PW:0]      count,
    output logic [PW-1:0]    tos_ptr,
    output logic             overflow,
    output logic             underflow
);

    localparam int CW = PW + 1;
    localparam logic [PW:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    ras_cmd_e         cmd;
    logic             mem_we;
    logic [PW-1:0]    mem_wa;
    logic [PW-1:0]    tos_inc;
    logic [PW:0]      restore_cnt_clamped;

    assign cmd     = ras_decode(flush, restore, push, pop, count != '0);
    // DEPTH is a power of two, so the PW-bit add wraps modulo DEPTH.
    assign tos_inc = tos_ptr + PW'(1);

    assign restore_cnt_clamped = (restore_cnt > FULL_CNT) ? FULL_CNT : restore_cnt;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = tos_inc;
        if (!reset) begin
            case (cmd)
                CMD_PUSH: begin
                    mem_we = 1'b1;
                    mem_wa = tos_inc;
                end
                CMD_REPLACE: begin
                    mem_we = 1'b1;
                    mem_wa = tos_ptr;
                end
                default: ;
            endcase
        end
    end

    // Storage is never reset; data_out is gated by count instead.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_ptr   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            case (cmd)
                CMD_FLUSH: begin
                    tos_ptr <= '0;
                    count   <= '0;
                end
                CMD_RESTORE: begin
                    tos_ptr <= restore_tos;
                    count   <= restore_cnt_clamped;
                end
                CMD_PUSH: begin
                    tos_ptr <= tos_inc;
                    // When full the pointer still advances, overwriting the
                    // oldest slot, and count saturates.
                    if (count == FULL_CNT)
                        overflow <= 1'b1;
                    else
                        count <= count + CW'(1);
                end
                CMD_POP: begin
                    if (count == '0) begin
                        underflow <= 1'b1;
                    end else begin
                        tos_ptr <= tos_ptr - PW'(1);
                        count   <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign data_out = empty ? '0 : mem[tos_ptr];

endmodule
